// File: rtl/chess_pkg.sv
// Shared chess board encodings: piece/colour codes, move word layout and the
// move-generation sequencer state type.
package chess_pkg;

    localparam int MOVE_W = 15;

    // Move word is {from_x, from_y, to_x, to_y, piece}, three bits per field.
    localparam int PIECE_LSB  = 0;
    localparam int TO_Y_LSB   = 3;
    localparam int TO_X_LSB   = 6;
    localparam int FROM_Y_LSB = 9;
    localparam int FROM_X_LSB = 12;

    typedef enum logic [2:0] {
        EMPTY   = 3'd0,
        PAWN    = 3'd1,
        KNIGHT  = 3'd2,
        BISHOP  = 3'd3,
        ROOK    = 3'd4,
        QUEEN   = 3'd5,
        KING    = 3'd6,
        NOTUSED = 3'd7
    } piece_t;

    typedef enum logic {
        WHITE = 1'b0,
        BLACK = 1'b1
    } colour_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        SETTLE  = 3'd2,
        COLLECT = 3'd3,
        DONE    = 3'd4
    } seq_state_t;

    function automatic logic [MOVE_W-1:0] pack_move(
        input logic [2:0] from_x,
        input logic [2:0] from_y,
        input logic [2:0] to_x,
        input logic [2:0] to_y,
        input piece_t     piece
    );
        return {from_x, from_y, to_x, to_y, piece};
    endfunction

endpackage

// File: rtl/move_gen_sequencer_if.sv
// Requester-side and consumer-side move handshakes of the move-generation
// sequencer, bundled so the sequencer and its environment share one bus.
interface move_gen_sequencer_if #(
    parameter int NREQ   = 8,
    parameter int MOVE_W = chess_pkg::MOVE_W,
    parameter int DEPTH  = 32
) ();

    // Both ports are valid/ready: a word moves on a cycle where valid and
    // ready are both high. req_ready is a one-hot grant and never depends on
    // a transfer happening; ml_valid never waits on ml_ready.
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*MOVE_W-1:0] req_move;
    logic [NREQ-1:0]        req_ready;
    logic                   ml_valid;
    logic [MOVE_W-1:0]      ml_move;
    logic                   ml_ready;
    logic [$clog2(DEPTH):0] ml_count;

    modport master (
        input  req_valid, req_move, ml_ready,
        output req_ready, ml_valid, ml_move, ml_count
    );

    modport slave (
        output req_valid, req_move, ml_ready,
        input  req_ready, ml_valid, ml_move, ml_count
    );

endinterface

// File: rtl/move_fifo.sv
// Show-ahead move FIFO with occupancy count and a synchronous flush that
// overrides any push or pop in the same cycle.
module move_fifo #(
    parameter int  DEPTH  = 32,
    parameter int  MOVE_W = 15,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [MOVE_W-1:0] push_data,
    input  logic              pop,
    output logic              valid,
    output logic [MOVE_W-1:0] head,
    output logic [CW-1:0]     count
);

    logic [MOVE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic              full;
    logic              do_push;
    logic              do_pop;

    // A pop at full does not free a slot for a push in the same cycle.
    assign full    = (cnt == CW'(DEPTH));
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & (cnt != '0) & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign valid = (cnt != '0);
    assign head  = mem[rd_ptr];
    assign count = cnt;

endmodule

// File: rtl/move_gen_sequencer.sv
// Runs one move-generation pass: broadcasts newboard, round-robin collects
// moves from the column requesters into the move FIFO, and signals completion.
module move_gen_sequencer #(
    parameter int NREQ   = 8,
    parameter int MOVE_W = chess_pkg::MOVE_W,
    parameter int DEPTH  = 32,
    parameter int NCELL  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  newboard,
    input  logic [NCELL-1:0]      cell_done,
    move_gen_sequencer_if.master  bus,
    output logic [7:0]            total_moves,
    output logic                  busy,
    output logic                  gen_done,
    output chess_pkg::seq_state_t state
);

    import chess_pkg::*;

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    seq_state_t        state_q;
    seq_state_t        state_d;
    logic              quiet_q;
    logic              quiet_d;
    logic              all_quiet;
    logic [IW-1:0]     rr_ptr;
    logic [NREQ-1:0]   grant;
    logic [IW-1:0]     gnt_idx;
    logic              found;
    logic              xfer;
    logic [MOVE_W-1:0] push_data;
    logic [CW-1:0]     fifo_count;
    logic              has_room;

    function automatic int rot_idx(input int base, input int k);
        return (base + k) % NREQ;
    endfunction

    // Cells are finished and no column still holds a move.
    assign all_quiet = (&cell_done) & ~(|bus.req_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            quiet_q <= 1'b0;
        end else begin
            state_q <= state_d;
            quiet_q <= quiet_d;
        end
    end

    always_comb begin
        state_d = state_q;
        quiet_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: state_d = SETTLE;
            // One dead cycle while the cells' registered done catches up.
            SETTLE: state_d = COLLECT;
            COLLECT: begin
                quiet_d = all_quiet;
                if (all_quiet && quiet_q) begin
                    state_d = DONE;
                    quiet_d = 1'b0;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign newboard = (state_q == LAUNCH);
    assign gen_done = (state_q == DONE);
    assign busy     = (state_q != IDLE);
    assign state    = state_q;

    // Round-robin search starting at rr_ptr, wrapping past the top column.
    assign has_room = (fifo_count < CW'(DEPTH));

    always_comb begin
        grant     = '0;
        gnt_idx   = '0;
        found     = 1'b0;
        push_data = '0;
        if ((state_q == COLLECT) && has_room) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!found && bus.req_valid[rot_idx(int'(rr_ptr), k)]) begin
                    found = 1'b1;
                    grant[rot_idx(int'(rr_ptr), k)] = 1'b1;
                    gnt_idx   = IW'(rot_idx(int'(rr_ptr), k));
                    push_data = bus.req_move[rot_idx(int'(rr_ptr), k)*MOVE_W +: MOVE_W];
                end
            end
        end
    end

    assign bus.req_ready = grant;
    assign xfer          = found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            rr_ptr <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_moves <= '0;
        end else if (state_q == LAUNCH) begin
            total_moves <= '0;
        end else if (xfer && (total_moves != 8'hFF)) begin
            total_moves <= total_moves + 1'b1;
        end
    end

    move_fifo #(
        .DEPTH  (DEPTH),
        .MOVE_W (MOVE_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (state_q == LAUNCH),
        .push      (xfer),
        .push_data (push_data),
        .pop       (bus.ml_ready),
        .valid     (bus.ml_valid),
        .head      (bus.ml_move),
        .count     (fifo_count)
    );

    assign bus.ml_count = fifo_count;

endmodule

// File: tb/tb_move_gen_sequencer.sv
// Randomized bench for move_gen_sequencer against a queue-based model of one
// move-generation pass.
module tb_move_gen_sequencer;

    import chess_pkg::*;

    localparam int NREQ  = 8;
    localparam int MW    = 15;
    localparam int DEPTH = 32;
    localparam int NCELL = 64;
    localparam int SRC_N = 64;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start;
    logic [NCELL-1:0] cell_done;
    logic             newboard;
    logic [7:0]       total_moves;
    logic             busy;
    logic             gen_done;
    seq_state_t       dbg_state;

    move_gen_sequencer_if #(.NREQ(NREQ), .MOVE_W(MW), .DEPTH(DEPTH)) bus ();

    move_gen_sequencer #(
        .NREQ(NREQ), .MOVE_W(MW), .DEPTH(DEPTH), .NCELL(NCELL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .newboard    (newboard),
        .cell_done   (cell_done),
        .bus         (bus),
        .total_moves (total_moves),
        .busy        (busy),
        .gen_done    (gen_done),
        .state       (dbg_state)
    );

    always #5 clk = ~clk;

    // Scoreboard / model state: exp_q is the expected FIFO content.
    int          n_tests;
    int          n_fail;
    logic [MW-1:0] exp_q[$];
    int          m_phase;   // 0 idle, 1 launch, 2 settle, 3 collect, 4 done
    int          m_quiet;
    int          m_rr;
    int          m_total;
    logic [MW-1:0] src_mem [NREQ][SRC_N];
    int          src_head [NREQ];
    int          src_tail [NREQ];
    int          grant_log[$];
    int          delivered;
    int          cyc;
    int          nb_cyc;
    int          gd_cyc;
    int          nb_count;
    logic        rand_mode;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic src_valid(input int i);
        return src_head[i] != src_tail[i];
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i] = src_valid(i);
            bus.req_move[i*MW +: MW] = src_valid(i) ? src_mem[i][src_head[i]] : '0;
        end
    endtask

    task automatic add_move(input int i);
        logic [MW-1:0] mv;
        mv = pack_move(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                       3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                       piece_t'($urandom_range(1, 6)));
        src_mem[i][src_tail[i]] = mv;
        src_tail[i]++;
    endtask

    task automatic clear_sources();
        for (int i = 0; i < NREQ; i++) begin
            src_head[i] = 0;
            src_tail[i] = 0;
        end
    endtask

    // Lowest requester at or above the pointer, else lowest below it.
    function automatic int model_grant();
        if (m_phase != 3 || exp_q.size() >= DEPTH) return -1;
        for (int i = m_rr; i < NREQ; i++) if (src_valid(i)) return i;
        for (int i = 0; i < m_rr; i++) if (src_valid(i)) return i;
        return -1;
    endfunction

    task automatic step();
        int              g;
        logic [NREQ-1:0] exp_ready;
        logic [NREQ-1:0] hs;
        logic            any_valid;
        logic            cond;
        @(negedge clk);
        g = model_grant();
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", bus.req_ready, exp_ready);
        check("newboard", newboard, m_phase == 1);
        check("gen_done", gen_done, m_phase == 4);
        check("busy", busy, m_phase != 0);
        check("ml_valid", bus.ml_valid, exp_q.size() != 0);
        check("ml_count", bus.ml_count, exp_q.size());
        check("total_moves", total_moves, m_total);
        if (exp_q.size() != 0) check("ml_move", bus.ml_move, exp_q[0]);
        if (newboard) begin nb_cyc = cyc; nb_count++; end
        if (gen_done) gd_cyc = cyc;
        hs = bus.req_valid & bus.req_ready;
        for (int i = 0; i < NREQ; i++) if (hs[i]) grant_log.push_back(i);

        any_valid = 1'b0;
        for (int i = 0; i < NREQ; i++) if (src_valid(i)) any_valid = 1'b1;
        cond = (&cell_done) && !any_valid;
        if (m_phase == 1) begin
            exp_q.delete();
            m_total = 0;
        end else begin
            if (exp_q.size() != 0 && bus.ml_ready) begin
                void'(exp_q.pop_front());
                delivered++;
            end
            if (g >= 0) begin
                exp_q.push_back(src_mem[g][src_head[g]]);
                m_total = (m_total < 255) ? m_total + 1 : 255;
                m_rr = (g + 1) % NREQ;
            end
        end
        case (m_phase)
            0: begin m_phase = start ? 1 : 0; m_quiet = 0; end
            1: begin m_phase = 2; m_quiet = 0; end
            2: begin m_phase = 3; m_quiet = 0; end
            3: begin
                if (cond && m_quiet == 1) begin
                    m_phase = 4;
                    m_quiet = 0;
                end else begin
                    m_quiet = cond ? 1 : 0;
                end
            end
            default: begin m_phase = 0; m_quiet = 0; end
        endcase

        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NREQ; i++) if (hs[i]) src_head[i]++;
        drive_reqs();
        if (rand_mode) begin
            bus.ml_ready = 1'($urandom_range(0, 1));
            cell_done = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : '1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        bus.ml_ready = 1'b0;
        cell_done = '1;
        clear_sources();
        drive_reqs();
        exp_q.delete();
        m_phase = 0;
        m_quiet = 0;
        m_rr = 0;
        m_total = 0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_ml_valid", bus.ml_valid, 0);
        check("rst_gen_done", gen_done, 0);
        check("rst_newboard", newboard, 0);
        check("rst_ml_count", bus.ml_count, 0);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_total", total_moves, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic start_pass();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (m_phase != 0 && n < budget) begin
            step();
            n++;
        end
        check("pass_budget", n < budget, 1);
        check("pass_end_busy", busy, 0);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        bus.ml_ready = 1'b1;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check("drain_budget", n < budget, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_order [6];
        n_tests = 0;
        n_fail = 0;
        cyc = 0;
        delivered = 0;
        rand_mode = 1'b0;
        exp_order = '{0, 3, 7, 0, 3, 7};
        do_reset();

        // Empty pass: one newboard pulse, gen_done 4 cycles later.
        nb_count = 0;
        start_pass();
        wait_idle(20);
        check("s1_nb_pulses", nb_count, 1);
        check("s1_gen_done_lat", gd_cyc - nb_cyc, 4);
        check("s1_ml_count", bus.ml_count, 0);
        check("s1_total", total_moves, 0);

        // Requesters 0, 3, 7 with two moves each.
        for (int r = 0; r < 2; r++) begin add_move(0); add_move(3); add_move(7); end
        drive_reqs();
        bus.ml_ready = 1'b1;
        grant_log.delete();
        start_pass();
        wait_idle(40);
        check("s2_grants", grant_log.size(), 6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++) check("s2_order", grant_log[i], exp_order[i]);
        check("s2_total", total_moves, 6);
        drain(10);

        // 40 moves into a 32-deep FIFO with the consumer stalled.
        clear_sources();
        for (int i = 0; i < NREQ; i++) for (int r = 0; r < 5; r++) add_move(i);
        drive_reqs();
        bus.ml_ready = 1'b0;
        delivered = 0;
        start_pass();
        repeat (50) step();
        check("s3_full_count", bus.ml_count, 32);
        check("s3_full_ready", bus.req_ready, 0);
        bus.ml_ready = 1'b1;
        step();
        check("s3_full_pop", bus.ml_count, 31);
        wait_idle(40);
        drain(60);
        check("s3_delivered", delivered, 40);
        check("s3_total", total_moves, 40);

        // Stale moves left over are flushed by the next launch.
        clear_sources();
        for (int r = 0; r < 5; r++) add_move(2);
        drive_reqs();
        bus.ml_ready = 1'b0;
        start_pass();
        wait_idle(30);
        check("s4_stale", bus.ml_count, 5);
        start = 1'b1;
        step();
        start = 1'b0;
        bus.ml_ready = 1'b1;
        step();
        check("s4_flushed", bus.ml_count, 0);
        wait_idle(20);

        // Total moves saturates at 255.
        clear_sources();
        for (int i = 0; i < NREQ; i++) for (int r = 0; r < 33; r++) add_move(i);
        drive_reqs();
        bus.ml_ready = 1'b1;
        start_pass();
        wait_idle(400);
        check("s5_total_sat", total_moves, 255);
        drain(10);

        // Reset in the middle of COLLECT with queued moves.
        clear_sources();
        for (int i = 0; i < 6; i++) begin add_move(i); add_move(i); end
        drive_reqs();
        bus.ml_ready = 1'b0;
        cell_done = '1;
        cell_done[5] = 1'b0;
        start_pass();
        begin
            int n;
            n = 0;
            while (exp_q.size() < 10 && n < 40) begin step(); n++; end
            check("s6_queued", bus.ml_count, 10);
        end
        do_reset();

        // Randomized passes.
        for (int p = 0; p < 20; p++) begin
            clear_sources();
            for (int i = 0; i < NREQ; i++) begin
                int nm;
                nm = $urandom_range(0, 5);
                for (int r = 0; r < nm; r++) add_move(i);
            end
            drive_reqs();
            rand_mode = 1'b1;
            bus.ml_ready = 1'($urandom_range(0, 1));
            cell_done = '1;
            start_pass();
            wait_idle(300);
            rand_mode = 1'b0;
            cell_done = '1;
            drain(60);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/move_gen_sequencer.md
Name: move_gen_sequencer

Overview:
- Sequences one move-generation pass over the 64-cell board array.
- Launches the pass by pulsing newboard to all cells, then round-robin arbitrates move-list requests from NREQ requesters (column units) into a show-ahead move FIFO.
- Detects pass completion from the cell done signals; the downstream search logic drains moves through a valid/ready port.

Parameters:
- NREQ, 8, number of move requesters (one per board column).
- MOVE_W, 15, move word width: {from_x[2:0], from_y[2:0], to_x[2:0], to_y[2:0], piece[2:0]}.
- DEPTH, 32, move FIFO entries; must be a power of 2, at least 2.
- NCELL, 64, number of cell done inputs.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a pass; honoured only in IDLE.
- newboard  out  1  broadcast to all cells; high exactly one cycle per pass.
- cell_done  in  NCELL  registered done from each cell.
- req_valid  in  NREQ  requester i holds a move.
- req_move  in  NREQ*MOVE_W  requester i move in bits [i*MOVE_W +: MOVE_W].
- req_ready  out  NREQ  one-hot grant; a move transfers when req_valid[i] & req_ready[i].
- ml_valid  out  1  FIFO non-empty.
- ml_move  out  MOVE_W  FIFO head.
- ml_ready  in  1  consumer pop.
- ml_count  out  $clog2(DEPTH)+1  FIFO occupancy.
- total_moves  out  8  moves accepted this pass, saturating at 255.
- busy  out  1  state != IDLE.
- gen_done  out  1  one-cycle pulse at end of pass.

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE; FIFO pointers and count are 0.
  - Round-robin pointer is 0; total_moves is 0.
  - Outputs newboard, gen_done, ml_valid and busy are all 0; req_ready is 0.
- Reset mid-pass abandons the pass with no gen_done, and the FIFO contents are lost.
- FSM:
  - IDLE: on start=1, go to LAUNCH. start in any other state is ignored.
  - LAUNCH (1 cycle): newboard=1; FIFO flushed (pointers and count set to 0); total_moves cleared; go to SETTLE.
  - SETTLE (1 cycle): covers the cells' registered done latency; cell_done is ignored; go to COLLECT.
  - COLLECT: arbitration is enabled. Exit when (&cell_done) & ~(|req_valid) holds for 2 consecutive cycles; go to DONE.
  - DONE (1 cycle): gen_done=1; go to IDLE.
- Arbitration (active only in COLLECT):
  - Grant the lowest index i >= rr_ptr with req_valid[i]; if none, wrap to the lowest i < rr_ptr.
  - Grant only when ml_count < DEPTH; at full, req_ready is all 0 (backpressure, no drop).
  - On a transfer, rr_ptr <= (i+1) mod NREQ; otherwise rr_ptr holds.
  - req_ready is a combinational function of req_valid, rr_ptr, state and ml_count.
  - At most one push per cycle.
- FIFO:
  - Push on grant; pop when ml_valid & ml_ready.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - At full, push is blocked even if a pop occurs in the same cycle.
  - Pointers wrap modulo DEPTH.
  - ml_move equals mem[rd_ptr]; it is don't-care when ml_valid=0.
  - The consumer may pop in any state, including IDLE after gen_done.
  - A pop in the LAUNCH cycle is discarded by the flush.
- total_moves increments on each accepted transfer and saturates at 255.
- Latency: a move granted in cycle t is visible on ml_valid/ml_move in cycle t+1.

Decomposition:
- chess_pkg holds:
  - Piece codes EMPTY..NOTUSED and colour codes WHITE/BLACK.
  - MOVE_W and move field offsets.
  - The FSM state enum {IDLE, LAUNCH, SETTLE, COLLECT, DONE}.
- Sub-module move_fifo (parameters DEPTH and MOVE_W; show-ahead; count output; synchronous flush input) is instantiated once.
- The arbiter and FSM stay in this module.

Test Plan:
- Reset then start with cell_done all 1 and no requests -> newboard high in cycle 1 only; gen_done pulses 4 cycles after LAUNCH; ml_count=0; total_moves=0.
- Requesters 0, 3 and 7 each hold 2 moves, ml_ready=1 -> grant order 0,3,7,0,3,7; ml_move sequence matches; total_moves=6.
- ml_ready=0 with 40 moves offered and DEPTH=32 -> ml_count stops at 32 and req_ready stays 0; then raise ml_ready -> all 40 moves are delivered in order with none lost.
- At full, req_valid=1 and ml_ready=1 in the same cycle -> pop occurs, no push, ml_count becomes 31; a push occurs in the next cycle.
- A second start with 5 stale moves left in the FIFO -> the LAUNCH cycle flushes them; ml_count=0 in the cycle after LAUNCH.
- rst_n asserted low during COLLECT with 10 entries queued -> immediate IDLE, ml_valid=0, no gen_done; a later start behaves normally.
